shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift/rotate engine for the 8-bit datapath, placed between operand fetch and register-file write-back as the sequential companion of the combinational shift unit. It accepts an operand, a shift amount and an operation, and shifts one bit position per clock. It reports `BUSY` so the control unit can stall the PC, then presents the result with a one-cycle `DONE` pulse. It also covers the operations the combinational unit lacks: arithmetic right shift, rotate right, and amounts of 8 or more.

## Interface
Parameters: none.

Ports:
- `CLK` input 1: system clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high reset; one clock, sampled on the rising edge of `CLK`.
- `START` input 1: request a new operation; sampled only in IDLE or DONE.
- `VALUE` input 8: operand; captured on the accepting edge.
- `AMOUNT` input 8: shift amount, unsigned; captured on the accepting edge.
- `SHIFT_OP` input 2: operation select.
  - 00 sll: logical left.
  - 01 srl: logical right.
  - 10 sra: arithmetic right.
  - 11 ror: rotate right.
- `RESULT` output 8: working/result register; valid when `DONE`=1 and held until the next accepted `START`.
- `BUSY` output 1: high while in SHIFT.
- `DONE` output 1: high for exactly one cycle in the DONE state.

## Operation
- States: IDLE, SHIFT, DONE.
- Effective count N is computed at the accepting edge:
  - ror: `AMOUNT[2:0]`.
  - sll, srl, sra: min(`AMOUNT`, 8).
- Accept on a rising edge with `START`=1 in IDLE or DONE:
  - `RESULT` <= `VALUE`, op latched, counter <= N.
  - Next state is SHIFT if N>0, otherwise DONE.
- SHIFT, one step per edge:
  - sll: {R[6:0],0}.
  - srl: {0,R[7:1]}.
  - sra: {R[7],R[7:1]}.
  - ror: {R[0],R[7:1]}.
  - Counter decrements each step. The step that brings the counter from 1 to 0 also moves the state to DONE.
- DONE, one cycle:
  - `START`=1: accept a new operation (back-to-back operation, no IDLE gap).
  - Otherwise: go to IDLE, with `RESULT` held.
- `START` in SHIFT is ignored and not queued.
- `VALUE`, `AMOUNT` and `SHIFT_OP` are don't-care outside the accepting edge.
- Results by operation:
  - sll or srl with N=8: 0x00.
  - sra with N=8: 0x00 or 0xFF, by sign.
  - ror with `AMOUNT` = 8: identity, N=0.
- `BUSY` and `DONE` are never high together.

## Timing
- Reset values: state IDLE, `RESULT`=0x00, `BUSY`=0, `DONE`=0, counter=0.
- `RESET` overrides everything, including mid-SHIFT and simultaneous `START`. The operation in progress is discarded, with no `DONE`.
- Latency from accepting edge k:
  - `BUSY`=1 in the cycles following edges k .. k+N-1.
  - `DONE`=1 in the cycle following edge k+N.
  - N=0 gives `DONE` in the cycle right after edge k, with `BUSY` never asserted.
  - Worst case: 8 cycles of `BUSY`, then `DONE`.
- Back-to-back: `START` held high during DONE gives a new accept with no idle cycle. Throughput is N+1 cycles per operation.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
Macro `SHIFT_SEQ_EARLY_EXIT_EN`.

- **Defined:** the sequencer moves to DONE as soon as further steps cannot change `RESULT`.
  - Checked on the accepting edge against the loaded value.
  - Checked on each SHIFT edge against the post-shift value.
  - sll/srl exit when the value is 0x00; sra exits when it is 0x00 or 0xFF. ror never exits early.
  - `RESULT` is identical to the non-early-exit result; only latency shrinks.
  - Examples: srl of 0x00 by 5 gives `DONE` the cycle after accept; sra 0x80 by 8 exits after 7 steps at 0xFF.
- **Undefined:** latency is always exactly N steps, as specified in Timing.

## Test plan
- **Reset:** `RESET` for 1 cycle -> `RESULT`=0x00, `BUSY`=0, `DONE`=0. Then `START` sll 0x01 by 3 -> `BUSY` for 3 cycles, `DONE` with `RESULT`=0x08.
- **Each operation on 0xB5 by 3:**
  - sll -> 0xA8.
  - srl -> 0x16.
  - sra -> 0xF6.
  - ror -> 0xB6.
  - Each case: exactly 3 `BUSY` cycles, then 1 `DONE` cycle.
- **Amount boundaries:**
  - sll 0xFF by 200 -> 0x00 after 8 `BUSY` cycles.
  - sra 0x80 by 9 -> 0xFF after 8 `BUSY` cycles (7 with `SHIFT_SEQ_EARLY_EXIT_EN`).
  - ror 0x5A by 8 -> `DONE` next cycle, `RESULT` 0x5A.
  - sll 0x5A by 0 -> `DONE` next cycle, `RESULT` 0x5A.
- **`START` during `BUSY`:** srl 0x80 by 4. Pulse `START` with sll 0x01 by 1 on the second `BUSY` cycle -> ignored; `DONE` with 0x08; state IDLE afterwards.
- **Back-to-back:** `START` held through `DONE`, second op ror 0x01 by 1 -> new accept on the `DONE` edge; second `DONE` one cycle later with 0x80.
- **Reset mid-operation:** sra 0x80 by 8. Assert `RESET` on the third `BUSY` cycle with `START`=1 -> next cycle all outputs at reset values, no `DONE`; a fresh `START` then works normally.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Bus between operand fetch / control and the multi-cycle shift sequencer.
// The master drives the request fields; the slave (sequencer) drives the
// registered result and status flags.
interface shift_sequencer_if;
  logic       START;
  logic [7:0] VALUE;
  logic [7:0] AMOUNT;
  logic [1:0] SHIFT_OP;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;

  modport master (
    output START, VALUE, AMOUNT, SHIFT_OP,
    input  RESULT, BUSY, DONE
  );

  modport slave (
    input  START, VALUE, AMOUNT, SHIFT_OP,
    output RESULT, BUSY, DONE
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine: one bit position per clock, BUSY while
// shifting, one-cycle DONE pulse with the result held afterwards.
// Ops: 00 sll, 01 srl, 10 sra, 11 ror. Shift amounts of 8 or more saturate
// to 8 for sll/srl/sra; ror uses AMOUNT[2:0].
// Optional feature: define SHIFT_SEQ_EARLY_EXIT_EN to finish as soon as
// further steps can no longer change RESULT (same result, shorter latency).
module shift_sequencer (
  input  logic             CLK,
  input  logic             RESET,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t     state;
  logic [7:0] result;
  logic [1:0] op;
  logic [3:0] count;
  logic       busy;
  logic       done;

  logic [7:0] shifted;
  logic       accept;
  logic [3:0] accept_count;
  logic       accept_to_done;
  logic       step_to_done;

  // One bit-position step of the selected operation.
  function automatic logic [7:0] step(input logic [7:0] r, input logic [1:0] o);
    case (o)
      OP_SLL:  return {r[6:0], 1'b0};
      OP_SRL:  return {1'b0, r[7:1]};
      OP_SRA:  return {r[7], r[7:1]};
      default: return {r[0], r[7:1]};
    endcase
  endfunction

  // Number of steps to run, fixed at the accepting edge.
  function automatic logic [3:0] eff_count(input logic [7:0] amt, input logic [1:0] o);
    if (o == OP_ROR) return {1'b0, amt[2:0]};
    return (amt >= 8'd8) ? 4'd8 : amt[3:0];
  endfunction

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // True when every further step of this op leaves the value unchanged.
  function automatic logic settled(input logic [7:0] r, input logic [1:0] o);
    case (o)
      OP_SLL, OP_SRL: return (r == 8'h00);
      OP_SRA:         return (r == 8'h00) || (r == 8'hFF);
      default:        return 1'b0;
    endcase
  endfunction
`endif

  assign bus.RESULT = result;
  assign bus.BUSY   = busy;
  assign bus.DONE   = done;

  // Accept decision, next shifted value and the "finish now" conditions.
  // NOTE: every signal gets a value on every path through this block, so no latch can be inferred.
  always_comb begin
    shifted      = step(result, op);
    accept       = bus.START && ((state == S_IDLE) || (state == S_DONE));
    accept_count = eff_count(bus.AMOUNT, bus.SHIFT_OP);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    accept_to_done = (accept_count == 4'd0) || settled(bus.VALUE, bus.SHIFT_OP);
    step_to_done   = (count == 4'd1) || settled(shifted, op);
`else
    accept_to_done = (accept_count == 4'd0);
    step_to_done   = (count == 4'd1);
`endif
  end

  // Sequencer FSM with registered RESULT/BUSY/DONE; synchronous reset wins.
  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      result <= 8'h00;
      op     <= OP_SLL;
      count  <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            result <= bus.VALUE;
            op     <= bus.SHIFT_OP;
            count  <= accept_count;
            if (accept_to_done) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        S_SHIFT: begin
          result <= shifted;
          count  <= count - 4'd1;
          if (step_to_done) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus random
// operations compared against an arithmetic reference model.
module tb_shift_sequencer;

  logic CLK = 1'b0;
  logic RESET;
  shift_sequencer_if bus ();

  shift_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  function automatic int eff_n(input logic [1:0] o, input logic [7:0] a);
    if (o == 2'b11) return int'(a) % 8;
    return (int'(a) > 8) ? 8 : int'(a);
  endfunction

  // Value after shifting v by n positions with op o.
  function automatic logic [7:0] apply(input logic [1:0] o, input logic [7:0] v, input int n);
    logic signed [7:0] s;
    logic [15:0]       t;
    logic [7:0]        r;
    case (o)
      2'b00: begin r = v << n; return r; end
      2'b01: return v >> n;
      2'b10: begin s = v; s = s >>> n; return s; end
      default: begin t = {v, v} >> n; return t[7:0]; end
    endcase
  endfunction

  function automatic logic [7:0] model_result(input logic [1:0] o, input logic [7:0] v, input logic [7:0] a);
    return apply(o, v, eff_n(o, a));
  endfunction

  function automatic int model_busy(input logic [1:0] o, input logic [7:0] v, input logic [7:0] a);
    int n;
    logic [7:0] x;
    n = eff_n(o, a);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    for (int k = 0; k < n; k++) begin
      x = apply(o, v, k);
      if (o != 2'b11 && (x == 8'h00 || (o == 2'b10 && x == 8'hFF))) return k;
    end
`else
    x = 8'h00;
`endif
    return n;
  endfunction

  // ---------------- driver ----------------
  // Issue one operation and follow it to DONE (bounded). Returns at #1 after
  // the edge that raised DONE.
  task automatic run_op(input logic [1:0] o, input logic [7:0] v, input logic [7:0] a,
                        output int busy_cyc, output logic [7:0] res,
                        output bit timed_out, output bit overlap);
    @(negedge CLK);
    bus.START = 1'b1; bus.SHIFT_OP = o; bus.VALUE = v; bus.AMOUNT = a;
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.VALUE = 8'($urandom); bus.AMOUNT = 8'($urandom); bus.SHIFT_OP = 2'($urandom);
    busy_cyc = 0; timed_out = 1'b1; overlap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.BUSY && bus.DONE) overlap = 1'b1;
      if (bus.DONE) begin timed_out = 1'b0; break; end
      if (bus.BUSY) busy_cyc++;
      @(posedge CLK); #1;
    end
    res = bus.RESULT;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int b; logic [7:0] r; bit to, ov;
    @(negedge CLK); RESET = 1'b1; bus.START = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; bus.START = 1'b0;
    n_cmp++; if (bus.RESULT !== 8'h00) begin n_err++; $display("FAIL reset_result got=%h exp=00", bus.RESULT); end
    n_cmp++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    n_cmp++; if (bus.DONE !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
    run_op(2'b00, 8'h01, 8'd3, b, r, to, ov);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL reset_first_op_timeout got=%b exp=0", to); end
    n_cmp++; if (b !== 3) begin n_err++; $display("FAIL reset_first_op_busy got=%0d exp=3", b); end
    n_cmp++; if (r !== 8'h08) begin n_err++; $display("FAIL reset_first_op_result got=%h exp=08", r); end
    @(posedge CLK); #1;
    n_cmp++; if (bus.DONE !== 1'b0) begin n_err++; $display("FAIL reset_first_op_done_width got=%b exp=0", bus.DONE); end
  endtask

  task automatic test_each_op();
    logic [7:0] exp_r [4] = '{8'hA8, 8'h16, 8'hF6, 8'hB6};
    int b; logic [7:0] r; bit to, ov;
    for (int i = 0; i < 4; i++) begin
      run_op(2'(i), 8'hB5, 8'd3, b, r, to, ov);
      n_cmp++; if (to !== 1'b0 || ov !== 1'b0) begin n_err++; $display("FAIL op%0d_handshake timeout=%b overlap=%b exp=0/0", i, to, ov); end
      n_cmp++; if (b !== 3) begin n_err++; $display("FAIL op%0d_busy got=%0d exp=3", i, b); end
      n_cmp++; if (r !== exp_r[i]) begin n_err++; $display("FAIL op%0d_result got=%h exp=%h", i, r, exp_r[i]); end
      @(posedge CLK); #1;
      n_cmp++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin n_err++; $display("FAIL op%0d_after_done done=%b busy=%b exp=0/0", i, bus.DONE, bus.BUSY); end
    end
  endtask

  task automatic test_boundaries();
    logic [1:0] ops [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
    logic [7:0] vals[4] = '{8'hFF, 8'h80, 8'h5A, 8'h5A};
    logic [7:0] amts[4] = '{8'd200, 8'd9, 8'd8, 8'd0};
    logic [7:0] exp_r[4] = '{8'h00, 8'hFF, 8'h5A, 8'h5A};
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    int exp_b[4] = '{8, 7, 0, 0};
`else
    int exp_b[4] = '{8, 8, 0, 0};
`endif
    int b; logic [7:0] r; bit to, ov;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], vals[i], amts[i], b, r, to, ov);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL bound%0d_timeout got=%b exp=0", i, to); end
      n_cmp++; if (b !== exp_b[i]) begin n_err++; $display("FAIL bound%0d_busy got=%0d exp=%0d", i, b, exp_b[i]); end
      n_cmp++; if (r !== exp_r[i]) begin n_err++; $display("FAIL bound%0d_result got=%h exp=%h", i, r, exp_r[i]); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_start_during_busy();
    int b; bit seen;
    @(negedge CLK);
    bus.START = 1'b1; bus.SHIFT_OP = 2'b01; bus.VALUE = 8'h80; bus.AMOUNT = 8'd4;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    b = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.DONE) begin seen = 1'b1; break; end
      if (bus.BUSY) begin
        b++;
        bus.START = (b == 2); bus.SHIFT_OP = 2'b00; bus.VALUE = 8'h01; bus.AMOUNT = 8'd1;
      end
      @(posedge CLK); #1;
      bus.START = 1'b0;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL ignore_start_timeout got=%b exp=1", seen); end
    n_cmp++; if (b !== 4) begin n_err++; $display("FAIL ignore_start_busy got=%0d exp=4", b); end
    n_cmp++; if (bus.RESULT !== 8'h08) begin n_err++; $display("FAIL ignore_start_result got=%h exp=08", bus.RESULT); end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      n_cmp++; if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.RESULT !== 8'h08)
        begin n_err++; $display("FAIL ignore_start_idle%0d busy=%b done=%b result=%h exp=0/0/08", i, bus.BUSY, bus.DONE, bus.RESULT); end
    end
  endtask

  task automatic test_back_to_back();
    int b; bit seen;
    @(negedge CLK);
    bus.START = 1'b1; bus.SHIFT_OP = 2'b00; bus.VALUE = 8'h03; bus.AMOUNT = 8'd2;
    @(posedge CLK); #1;
    bus.SHIFT_OP = 2'b11; bus.VALUE = 8'h01; bus.AMOUNT = 8'd1;  // START stays high
    b = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.DONE) begin seen = 1'b1; break; end
      if (bus.BUSY) b++;
      @(posedge CLK); #1;
    end
    n_cmp++; if (seen !== 1'b1 || b !== 2) begin n_err++; $display("FAIL b2b_first_op done_seen=%b busy=%0d exp=1/2", seen, b); end
    n_cmp++; if (bus.RESULT !== 8'h0C) begin n_err++; $display("FAIL b2b_first_result got=%h exp=0C", bus.RESULT); end
    @(posedge CLK); #1;
    bus.START = 1'b0;
    n_cmp++; if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept busy=%b done=%b exp=1/0", bus.BUSY, bus.DONE); end
    @(posedge CLK); #1;
    n_cmp++; if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0) begin n_err++; $display("FAIL b2b_second_done done=%b busy=%b exp=1/0", bus.DONE, bus.BUSY); end
    n_cmp++; if (bus.RESULT !== 8'h80) begin n_err++; $display("FAIL b2b_second_result got=%h exp=80", bus.RESULT); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_op();
    int b; logic [7:0] r; bit to, ov;
    @(negedge CLK);
    bus.START = 1'b1; bus.SHIFT_OP = 2'b10; bus.VALUE = 8'h80; bus.AMOUNT = 8'd8;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    n_cmp++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got=%b exp=1", bus.BUSY); end
    RESET = 1'b1; bus.START = 1'b1; bus.SHIFT_OP = 2'b00; bus.VALUE = 8'h11; bus.AMOUNT = 8'd1;
    @(posedge CLK); #1;
    RESET = 1'b0; bus.START = 1'b0;
    n_cmp++; if (bus.RESULT !== 8'h00 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0)
      begin n_err++; $display("FAIL midrst_outputs result=%h busy=%b done=%b exp=00/0/0", bus.RESULT, bus.BUSY, bus.DONE); end
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      n_cmp++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin n_err++; $display("FAIL midrst_quiet%0d done=%b busy=%b exp=0/0", i, bus.DONE, bus.BUSY); end
    end
    run_op(2'b10, 8'h80, 8'd3, b, r, to, ov);
    n_cmp++; if (to !== 1'b0 || b !== 3 || r !== 8'hF0)
      begin n_err++; $display("FAIL midrst_fresh_op timeout=%b busy=%0d result=%h exp=0/3/F0", to, b, r); end
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    int b, eb; logic [7:0] r, er, v, a; logic [1:0] o; bit to, ov;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1:       v = 8'hFF;
        default: v = 8'($urandom);
      endcase
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      er = model_result(o, v, a);
      eb = model_busy(o, v, a);
      run_op(o, v, a, b, r, to, ov);
      n_cmp++; if (to !== 1'b0 || ov !== 1'b0) begin n_err++; $display("FAIL rand%0d_handshake op=%0d v=%h a=%0d timeout=%b overlap=%b exp=0/0", i, o, v, a, to, ov); end
      n_cmp++; if (b !== eb) begin n_err++; $display("FAIL rand%0d_busy op=%0d v=%h a=%0d got=%0d exp=%0d", i, o, v, a, b, eb); end
      n_cmp++; if (r !== er) begin n_err++; $display("FAIL rand%0d_result op=%0d v=%h a=%0d got=%h exp=%h", i, o, v, a, r, er); end
      @(posedge CLK); #1;
      n_cmp++; if (bus.DONE !== 1'b0 || bus.RESULT !== er) begin n_err++; $display("FAIL rand%0d_hold done=%b result=%h exp=0/%h", i, bus.DONE, bus.RESULT, er); end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    RESET = 1'b1;
    bus.START = 1'b0; bus.VALUE = 8'h00; bus.AMOUNT = 8'h00; bus.SHIFT_OP = 2'b00;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    test_reset();
    test_each_op();
    test_boundaries();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
